// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: mul/div sequencer states, default
// latencies and the bubble encoding loaded into ID/EX.
package mips_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MUL_CYCLES_DEFAULT = 4;
  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/md_timer.sv
// Mul/div busy sequencer: loads latency-1 on start, counts down, flags the
// final busy cycle.
module md_timer
  import mips_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy,
  output logic done
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  md_state_e  state, state_next;
  logic [5:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_BUSY;
          cnt_next   = div ? DIV_LOAD : MUL_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt == '0) state_next = ST_IDLE;
        else           cnt_next   = cnt - 6'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_BUSY);
  assign done = busy && (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use and mul/div stalls, branch flush,
// mul/div sequencing and a saturating stall-cycle counter.
module pipe_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_md_start,
  input  logic        id_md_div,
  input  logic        id_hilo_rd,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_br_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  logic        lu, mdh, stall;
  logic [31:0] stall_q;

  assign lu = ex_memread && (ex_rd != REG_ZERO) &&
              ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  assign mdh   = md_busy && (id_md_start || id_hilo_rd);
  assign stall = (lu || mdh) && !ex_br_taken;

  // While reset is held the front end is frozen with both stages flushed.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_start   = 1'b0;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else begin
      md_start = id_md_start && !md_busy;
    end
  end

  md_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .div   (id_md_div),
    .busy  (md_busy),
    .done  (md_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      stall_q <= '0;
    else if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard vector table plus multi-cycle
// mul/div, reset and saturation sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, id_md_start, id_md_div, id_hilo_rd;
  logic        ex_memread, ex_br_taken;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, md_start, md_busy, md_done;
  logic [31:0] stall_cnt;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [31:0] exp_cnt;

  pipe_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_start(id_md_start), .id_md_div(id_md_div), .id_hilo_rd(id_hilo_rd),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, rd;
    logic       use_rs, use_rt, mds, mdd, hilo, memrd, br;
    logic       e_pc, e_ifid, e_ifl, e_idfl, e_mds;
  } vec_t;

  vec_t vecs[10];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; id_md_start = 0; id_md_div = 0;
    id_hilo_rd = 0; ex_memread = 0; ex_br_taken = 0;
  endtask

  initial begin
    //            name        rs  rt  rd  urs urt mds mdd hil mrd br  pc  ifd ifl idf mds
    vecs[0] = '{"quiet",      0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  0,  0,  0};
    vecs[1] = '{"lu_rs",      5,  0,  5,  1,  0,  0,  0,  0,  1,  0,  0,  0,  0,  1,  0};
    vecs[2] = '{"lu_rd0",     0,  0,  0,  1,  0,  0,  0,  0,  1,  0,  1,  1,  0,  0,  0};
    vecs[3] = '{"lu_rt",      1,  7,  7,  0,  1,  0,  0,  0,  1,  0,  0,  0,  0,  1,  0};
    vecs[4] = '{"rt_unused",  1,  7,  7,  0,  0,  0,  0,  0,  1,  0,  1,  1,  0,  0,  0};
    vecs[5] = '{"no_load",    5,  0,  5,  1,  0,  0,  0,  0,  0,  0,  1,  1,  0,  0,  0};
    vecs[6] = '{"br_beats_lu",5,  0,  5,  1,  0,  0,  0,  0,  1,  1,  1,  1,  1,  1,  0};
    vecs[7] = '{"md_lu",      5,  0,  5,  1,  0,  1,  0,  0,  1,  0,  0,  0,  0,  1,  0};
    vecs[8] = '{"hilo_idle",  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  1,  1,  0,  0,  0};
    vecs[9] = '{"rs_unused",  9,  3,  9,  0,  1,  0,  0,  0,  1,  0,  1,  1,  0,  0,  0};

    rst_n = 0;
    idle_inputs();
    #3;
    chk1("rst_pc_en", pc_en, 0);
    chk1("rst_ifid_en", ifid_en, 0);
    chk1("rst_ifid_flush", ifid_flush, 1);
    chk1("rst_idex_flush", idex_flush, 1);
    chk1("rst_md_start", md_start, 0);
    chk1("rst_md_busy", md_busy, 0);
    chk1("rst_md_done", md_done, 0);
    chk32("rst_stall_cnt", stall_cnt, 0);
    exp_cnt = 0;
    @(negedge clk) rst_n = 1;

    foreach (vecs[i]) begin
      @(negedge clk);
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
      id_md_start = vecs[i].mds; id_md_div = vecs[i].mdd; id_hilo_rd = vecs[i].hilo;
      ex_memread = vecs[i].memrd; ex_br_taken = vecs[i].br;
      #1;
      chk1({vecs[i].name, "_pc_en"}, pc_en, vecs[i].e_pc);
      chk1({vecs[i].name, "_ifid_en"}, ifid_en, vecs[i].e_ifid);
      chk1({vecs[i].name, "_ifid_flush"}, ifid_flush, vecs[i].e_ifl);
      chk1({vecs[i].name, "_idex_flush"}, idex_flush, vecs[i].e_idfl);
      chk1({vecs[i].name, "_md_start"}, md_start, vecs[i].e_mds);
      if (!vecs[i].e_pc) exp_cnt++;
      @(posedge clk); #1;
      chk32({vecs[i].name, "_stall_cnt"}, stall_cnt, exp_cnt);
      chk1({vecs[i].name, "_busy"}, md_busy, 0);
    end

    // Divide with an mfhi arriving at busy cycle 10.
    @(negedge clk);
    idle_inputs();
    id_md_start = 1; id_md_div = 1;
    #1 chk1("div_md_start", md_start, 1);
    @(posedge clk); #1;
    for (int k = 1; k <= 32; k++) begin
      chk1($sformatf("div_busy_c%0d", k), md_busy, 1);
      chk1($sformatf("div_done_c%0d", k), md_done, k == 32);
      @(negedge clk);
      id_md_start = 0;
      id_hilo_rd = (k >= 10);
      #1;
      chk1($sformatf("div_pc_en_c%0d", k), pc_en, k < 10);
      chk1($sformatf("div_md_start_c%0d", k), md_start, 0);
      if (k >= 10) exp_cnt++;
      @(posedge clk); #1;
    end
    chk1("div_busy_c33", md_busy, 0);
    chk1("div_done_c33", md_done, 0);
    chk32("div_stall_cnt", stall_cnt, exp_cnt);
    @(negedge clk); #1;
    chk1("div_mfhi_proceeds", pc_en, 1);
    chk1("div_mfhi_no_bubble", idex_flush, 0);

    // Back-to-back multiplies: 4 busy, 1 gap cycle with the second start, 4 busy.
    idle_inputs();
    id_md_start = 1;
    #1 chk1("mul1_md_start", md_start, 1);
    @(posedge clk); #1;
    for (int c = 1; c <= 10; c++) begin
      chk1($sformatf("b2b_busy_c%0d", c), md_busy, (c != 5) && (c != 10));
      chk1($sformatf("b2b_done_c%0d", c), md_done, (c == 4) || (c == 9));
      @(negedge clk);
      id_md_start = (c <= 5);
      #1;
      chk1($sformatf("b2b_md_start_c%0d", c), md_start, c == 5);
      chk1($sformatf("b2b_pc_en_c%0d", c), pc_en, c >= 5);
      if (c < 5) exp_cnt++;
      @(posedge clk); #1;
    end
    chk32("b2b_stall_cnt", stall_cnt, exp_cnt);

    // Branch taken while busy: flushes the front end but keeps the divide running.
    @(negedge clk);
    idle_inputs();
    id_md_start = 1; id_md_div = 1;
    @(posedge clk); #1;
    for (int k = 1; k <= 7; k++) begin
      chk1($sformatf("rdiv_busy_c%0d", k), md_busy, 1);
      chk1($sformatf("rdiv_done_c%0d", k), md_done, 0);
      @(negedge clk);
      id_md_start = 0;
      ex_br_taken = (k == 3);
      if (k == 3) begin
        #1;
        chk1("br_busy_ifid_flush", ifid_flush, 1);
        chk1("br_busy_pc_en", pc_en, 1);
      end
      if (k == 7) break;
      @(posedge clk); #1;
    end
    // Reset mid-divide at busy cycle 7.
    rst_n = 0;
    #1;
    chk1("rdiv_rst_busy", md_busy, 0);
    chk1("rdiv_rst_done", md_done, 0);
    chk32("rdiv_rst_stall_cnt", stall_cnt, 0);
    exp_cnt = 0;
    @(posedge clk); #1;
    chk1("rdiv_rst_hold_done", md_done, 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    id_md_start = 1; id_md_div = 0;
    #1 chk1("rmul_md_start", md_start, 1);
    @(posedge clk); #1;
    for (int c = 1; c <= 5; c++) begin
      chk1($sformatf("rmul_busy_c%0d", c), md_busy, c <= 4);
      chk1($sformatf("rmul_done_c%0d", c), md_done, c == 4);
      @(negedge clk);
      id_md_start = 0;
      @(posedge clk); #1;
    end

    // Saturation of the stall counter.
    @(negedge clk);
    idle_inputs();
    force dut.stall_q = 32'hFFFF_FFFE;
    #1 release dut.stall_q;
    #1 chk32("sat_preload", stall_cnt, 32'hFFFF_FFFE);
    ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    for (int s = 1; s <= 3; s++) begin
      @(posedge clk); #1;
      chk32($sformatf("sat_cycle%0d", s), stall_cnt, 32'hFFFF_FFFF);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the MIPS32 datapath. It generates the hold and bubble controls for the PC, the IF/ID register and the ID/EX register (`idex`). It detects load-use hazards against the instruction in EX, flushes on taken branches, and sequences the multi-cycle multiply/divide unit with an internal busy counter. It also keeps a saturating count of stall cycles for performance debug.

## Interface
- `MUL_CYCLES`, 4: multiply latency in cycles (≥2).
- `DIV_CYCLES`, 32: divide latency in cycles (≥2).
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  5 each: source register numbers of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1 each: the ID instruction actually reads rs / rt.
- `id_md_start`  in  1: the ID instruction is a mult/div.
- `id_md_div`  in  1: 1 = div, 0 = mult; valid with `id_md_start`.
- `id_hilo_rd`  in  1: the ID instruction is mfhi/mflo.
- `ex_rd`  in  5: destination register of the instruction in EX (ID/EX `o_rd`).
- `ex_memread`  in  1: the EX instruction is a load.
- `ex_br_taken`  in  1: the EX branch/jump resolved taken.
- `pc_en`  out  1: PC load enable.
- `ifid_en`  out  1: IF/ID load enable.
- `ifid_flush`  out  1: IF/ID clears to NOP.
- `idex_flush`  out  1: ID/EX loads a bubble (rd=0, no side effects).
- `md_start`  out  1: one-cycle start pulse to the mul/div unit.
- `md_busy`  out  1: the mul/div unit is in progress.
- `md_done`  out  1: one-cycle pulse in the final busy cycle.
- `stall_cnt`  out  32: saturating count of stall cycles.

## Operation
- **Load-use hazard:** `lu = ex_memread & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd))`.
- **Mul/div hazard:** `mdh = md_busy & (id_md_start | id_hilo_rd)`.
- **Stall:** `stall = (lu | mdh) & ~ex_br_taken`.
- **Priority:** branch flush > mul/div hazard > load-use.
- **Branch taken:** `ifid_flush=1`, `idex_flush=1`, `pc_en=1`, `ifid_en=1`. Any pending stall is cancelled.
- **Stall:** `pc_en=0`, `ifid_en=0`, `idex_flush=1`, `ifid_flush=0`.
- **Otherwise:** `pc_en=1`, `ifid_en=1`, both flushes 0.
- **State machine:** 2 states, IDLE and BUSY; down-counter `cnt` is 6 bits wide.
  - IDLE → BUSY when `id_md_start & ~stall & ~ex_br_taken`. The controller asserts `md_start` that cycle (combinational) and loads `cnt` with `(id_md_div ? DIV_CYCLES : MUL_CYCLES) - 1`.
  - BUSY: `cnt` decrements each cycle.
  - When `cnt==0` in BUSY, `md_done=1` and the next state is IDLE.
  - A new `id_md_start` in the `md_done` cycle is still stalled (mdh). It issues in the following cycle.
  - `md_busy` = state==BUSY.
- **Stall counter:** `stall_cnt` increments by 1 on every cycle with `stall=1` and saturates at 0xFFFF_FFFF.
- **`ex_br_taken` during BUSY:** does not abort the running mul/div. The issuing instruction has already left ID.

## Timing
- **Reset (`rst_n`=0, asynchronous):**
  - State goes to IDLE; `cnt=0`; `stall_cnt=0`.
  - Outputs while reset is held: `pc_en=0`, `ifid_en=0`, `ifid_flush=1`, `idex_flush=1`, `md_start=0`, `md_busy=0`, `md_done=0`.
- **Reset mid-operation:** a reset during BUSY abandons the operation with no `md_done`. Normal operation resumes on the first edge after deassertion.
- **Output paths:** hazard outputs are combinational from current inputs and state, with zero latency. `md_busy`, `md_done` and `stall_cnt` are registered.
- **Load-use duration:** exactly 1 stall cycle. The next cycle, the bubble sits in EX (`ex_memread=0`).
- **Mul/div latency:** `md_busy` is high for exactly N cycles, starting the cycle after `md_start`. `md_done` is in the Nth cycle.

## Structure
- Shared package `mips_pkg`: state encodings `ST_IDLE`/`ST_BUSY`, default `MUL_CYCLES`/`DIV_CYCLES` constants, and the NOP/bubble constant also used by `idex`.
- One natural sub-module, `md_timer`: the load/decrement/done counter. The hazard logic and `stall_cnt` stay in `pipe_ctrl`.

## Test plan
- **Load-use:** `ex_memread=1`, `ex_rd=5`, `id_rs=5`, `id_use_rs=1` → one cycle with `pc_en=0`, `ifid_en=0`, `idex_flush=1`; `stall_cnt` becomes 1. The same stimulus with `ex_rd=0` gives no stall.
- **Branch beats hazard:** load-use condition plus `ex_br_taken=1` → `ifid_flush=1`, `idex_flush=1`, `pc_en=1`; `stall_cnt` unchanged.
- **Divide:** `id_md_start=1`, `id_md_div=1` → `md_start` pulse, then `md_busy` high 32 cycles, `md_done` in cycle 32. An mfhi presented at cycle 10 stalls through cycle 32 and proceeds in cycle 33.
- **Back-to-back multiplies:** second mult presented during BUSY → stalled through `md_done`; `md_start` fires the next cycle; total 4+4 busy cycles plus 1 gap cycle.
- **Reset mid-divide:** assert `rst_n=0` at busy cycle 7 → `md_busy=0` and `stall_cnt=0` immediately, with no `md_done`. After release, a mult completes normally in 4 cycles.
- **Saturation:** force `stall_cnt` to 0xFFFF_FFFE, then apply 3 stall cycles → reads 0xFFFF_FFFF.
